// File: rtl/ser_tx16_pkg.sv
// Shared types and constants for the ser_tx16 serializer.
// States, rate-select codes and the default word width.
package ser_tx16_pkg;

  localparam int WORD_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] RATE_DIV2  = 2'd0;
  localparam logic [1:0] RATE_DIV4  = 2'd1;
  localparam logic [1:0] RATE_DIV8  = 2'd2;
  localparam logic [1:0] RATE_DIV16 = 2'd3;

endpackage

// File: rtl/edge_rise4.sv
// Rising-edge detector for the four divider levels.
// rise_o[k] is high for one cycle after div_i[k] goes 0->1.
module edge_rise4 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] div_i,
  output logic [3:0] rise_o
);

  logic [3:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q <= '0;
    end else begin
      prev_q <= div_i;
    end
  end

  assign rise_o = div_i & ~prev_q;

endmodule

// File: rtl/ser_tx16.sv
// MSB-first serializer paced by an external clock divider.
// Define SER_TX16_PARITY_EN to append an even-parity bit per frame.
module ser_tx16
  import ser_tx16_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              iClkIN,
  input  logic              reset,
  input  logic              iDiv2,
  input  logic              iDiv4,
  input  logic              iDiv8,
  input  logic              iDiv16,
  input  logic [1:0]        iRateSel,
  input  logic [WORD_W-1:0] iData,
  input  logic              iLoad,
  output logic              oBusy,
  output logic              oSerOut,
  output logic              oBitStrobe,
  output logic              oDone
);

`ifdef SER_TX16_PARITY_EN
  localparam int NBITS = WORD_W + 1;
`else
  localparam int NBITS = WORD_W;
`endif
  localparam int CNT_W = $clog2(WORD_W + 2);

  state_e           state_q, state_d;
  logic [NBITS-1:0] sh_q, sh_d;
  logic [1:0]       rate_q, rate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_q, ser_d;
  logic             stb_q, stb_d;
  logic [3:0]       rise;
  logic             act;
  logic [NBITS-1:0] load_val;

  edge_rise4 u_edge (
    .clk_i  (iClkIN),
    .rst_ni (reset),
    .div_i  ({iDiv16, iDiv8, iDiv4, iDiv2}),
    .rise_o (rise)
  );

  always_comb begin
    act = 1'b0;
    unique case (rate_q)
      RATE_DIV2:  act = rise[0];
      RATE_DIV4:  act = rise[1];
      RATE_DIV8:  act = rise[2];
      RATE_DIV16: act = rise[3];
      default:    act = 1'b0;
    endcase
  end

`ifdef SER_TX16_PARITY_EN
  assign load_val = {iData, ^iData};
`else
  assign load_val = iData;
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rate_d  = rate_q;
    cnt_d   = cnt_q;
    ser_d   = ser_q;
    stb_d   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        ser_d   = 1'b1;
        state_d = ST_IDLE;
        if (iLoad) begin
          sh_d    = load_val;
          rate_d  = iRateSel;
          cnt_d   = '0;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (act) begin
          ser_d   = sh_q[NBITS-1];
          sh_d    = sh_q << 1;
          cnt_d   = CNT_W'(1);
          stb_d   = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (act) begin
          // Strobe after the last bit ends the frame.
          if (cnt_q == CNT_W'(NBITS)) begin
            ser_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            ser_d = sh_q[NBITS-1];
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
            stb_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClkIN) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      rate_q  <= RATE_DIV2;
      cnt_q   <= '0;
      ser_q   <= 1'b1;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rate_q  <= rate_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      stb_q   <= stb_d;
    end
  end

  assign oBusy      = (state_q == ST_SYNC) || (state_q == ST_SHIFT);
  assign oDone      = (state_q == ST_DONE);
  assign oSerOut    = ser_q;
  assign oBitStrobe = stb_q;

endmodule

// File: tb/tb_ser_tx16.sv
// Self-checking bench for ser_tx16: table vectors, corner
// sequences and random frames against a frame-level model.
module tb_ser_tx16;

`ifdef SER_TX16_PARITY_EN
  localparam int NB  = 17;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 16;
  localparam bit PAR = 1'b0;
`endif

  logic        iClkIN = 1'b0;
  logic        reset = 1'b0;
  logic        iLoad = 1'b0;
  logic [1:0]  iRateSel = 2'd0;
  logic [15:0] iData = 16'h0;
  logic [7:0]  dcnt = 8'h0;
  logic        iDiv2, iDiv4, iDiv8, iDiv16;
  logic        oBusy, oSerOut, oBitStrobe, oDone;

  assign iDiv2  = dcnt[0];
  assign iDiv4  = dcnt[1];
  assign iDiv8  = dcnt[2];
  assign iDiv16 = dcnt[3];

  ser_tx16 #(.WORD_W(16)) dut (
    .iClkIN     (iClkIN),
    .reset      (reset),
    .iDiv2      (iDiv2),
    .iDiv4      (iDiv4),
    .iDiv8      (iDiv8),
    .iDiv16     (iDiv16),
    .iRateSel   (iRateSel),
    .iData      (iData),
    .iLoad      (iLoad),
    .oBusy      (oBusy),
    .oSerOut    (oSerOut),
    .oBitStrobe (oBitStrobe),
    .oDone      (oDone)
  );

  always #5 iClkIN = ~iClkIN;

  // free-running upstream divider
  always @(negedge iClkIN) dcnt = dcnt + 8'd1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  bit c_ser  [0:511];
  bit c_stb  [0:511];
  bit c_busy [0:511];
  bit c_done [0:511];
  int c_len;
  int c_done_at;

  task automatic start_load(input logic [15:0] w,
                            input logic [1:0] r);
    iData    = w;
    iRateSel = r;
    iLoad    = 1'b1;
    @(negedge iClkIN);
    iLoad = 1'b0;
  endtask

  // Record one frame cycle by cycle, optionally disturbing
  // inputs mid-frame or chaining a load into the done cycle.
  task automatic capture(input logic [1:0] r, input bit interfere,
                         input bit chain, input logic [15:0] nw,
                         input logic [1:0] nr);
    int p;
    p = 2 << r;
    c_done_at = -1;
    c_len = 0;
    for (int n = 1; n < 512; n++) begin
      c_ser[n]  = oSerOut;
      c_stb[n]  = oBitStrobe;
      c_busy[n] = oBusy;
      c_done[n] = oDone;
      c_len = n;
      if (interfere) begin
        if (n == 4*p + 3) begin
          iLoad = 1'b1;
          iData = 16'hFFFF;
          iRateSel = ~r;
        end else if (n == 4*p + 4) begin
          iLoad = 1'b0;
        end else if (n == 7*p + 1) begin
          iRateSel = r ^ 2'b01;
        end
      end
      if (oDone) begin
        c_done_at = n;
        if (chain) begin
          iLoad = 1'b1;
          iData = nw;
          iRateSel = nr;
        end
        break;
      end
      @(negedge iClkIN);
    end
    if (chain) begin
      @(negedge iClkIN);
      iLoad = 1'b0;
    end
  endtask

  // Compare the captured frame with the expected bit sequence.
  task automatic analyze(input logic [15:0] w, input logic [1:0] r,
                         output int flen, output int last_bit);
    bit b [0:16];
    int p, f, bad, idx, nstb;
    p = 2 << r;
    flen = -1;
    last_bit = -1;
    for (int k = 0; k < 16; k++) b[k] = w[15-k];
    b[16] = ^w;
    chk("done_seen", c_done_at > 0, 1);
    if (c_done_at <= 0) return;
    f = -1;
    for (int n = 1; n <= c_len; n++)
      if (c_stb[n] && f < 0) f = n;
    chk("first_strobe_lat", (f >= 2 && f <= p + 1), 1);
    if (f < 0) return;
    bad = 0;
    for (int n = 1; n < f; n++)
      if (!c_ser[n] || !c_busy[n] || c_done[n]) bad++;
    chk("sync_idle_high", bad, 0);
    for (int k = 0; k < NB; k++) begin
      bad = 0;
      for (int j = 0; j < p; j++) begin
        idx = f + k*p + j;
        if (idx >= c_done_at) bad++;
        else if (c_ser[idx] != b[k] || c_stb[idx] != (j == 0) ||
                 !c_busy[idx] || c_done[idx]) bad++;
      end
      chk($sformatf("bit%0d_w%h_r%0d", k, w, r), bad, 0);
    end
    nstb = 0;
    for (int n = 1; n <= c_len; n++) nstb += int'(c_stb[n]);
    chk("strobe_count", nstb, NB);
    flen = c_done_at - f;
    chk("frame_len", flen, NB*p);
    chk("done_busy_low", c_busy[c_done_at], 0);
    chk("done_ser_high", c_ser[c_done_at], 1);
    idx = f + (NB-1)*p;
    if (idx < 512) last_bit = int'(c_ser[idx]);
  endtask

  task automatic quiet(input int ncyc, input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge iClkIN);
      if (oDone || oBusy || oBitStrobe || !oSerOut) bad++;
    end
    chk(nm, bad, 0);
  endtask

  typedef struct {
    logic [15:0] w;
    logic [1:0]  r;
    int          exp_len;
    bit          last_np;
    bit          last_par;
  } vec_t;

  vec_t tbl [0:6];

  initial begin
    int flen, lb, seen, nst;
    logic [15:0] rw;
    logic [1:0]  rr;

    tbl[0] = '{16'hA5C3, 2'd0, NB*2,  1'b1, 1'b0};
    tbl[1] = '{16'h8001, 2'd3, NB*16, 1'b1, 1'b0};
    tbl[2] = '{16'h0007, 2'd1, NB*4,  1'b1, 1'b1};
    tbl[3] = '{16'h0003, 2'd2, NB*8,  1'b1, 1'b0};
    tbl[4] = '{16'hFFFF, 2'd0, NB*2,  1'b1, 1'b0};
    tbl[5] = '{16'h0000, 2'd1, NB*4,  1'b0, 1'b0};
    tbl[6] = '{16'h1234, 2'd2, NB*8,  1'b0, 1'b1};

    repeat (3) @(negedge iClkIN);
    chk("rst_ser", oSerOut, 1);
    chk("rst_busy", oBusy, 0);
    chk("rst_stb", oBitStrobe, 0);
    chk("rst_done", oDone, 0);
    reset = 1'b1;
    @(negedge iClkIN);

    for (int i = 0; i < 7; i++) begin
      start_load(tbl[i].w, tbl[i].r);
      capture(tbl[i].r, 1'b0, 1'b0, 16'h0, 2'd0);
      analyze(tbl[i].w, tbl[i].r, flen, lb);
      chk($sformatf("tbl%0d_len", i), flen, tbl[i].exp_len);
      chk($sformatf("tbl%0d_last", i), lb,
          PAR ? int'(tbl[i].last_par) : int'(tbl[i].last_np));
      repeat (2) @(negedge iClkIN);
    end

    // mid-frame load and rate change must be ignored
    start_load(16'hA5C3, 2'd1);
    capture(2'd1, 1'b1, 1'b0, 16'h0, 2'd0);
    analyze(16'hA5C3, 2'd1, flen, lb);
    quiet(40, "no_extra_done_r1");
    start_load(16'h8001, 2'd3);
    capture(2'd3, 1'b1, 1'b0, 16'h0, 2'd0);
    analyze(16'h8001, 2'd3, flen, lb);
    quiet(40, "no_extra_done_r3");

    // load in the done cycle: back-to-back frames
    start_load(16'hA5C3, 2'd0);
    capture(2'd0, 1'b0, 1'b1, 16'h1234, 2'd2);
    analyze(16'hA5C3, 2'd0, flen, lb);
    capture(2'd2, 1'b0, 1'b0, 16'h0, 2'd0);
    analyze(16'h1234, 2'd2, flen, lb);
    repeat (3) @(negedge iClkIN);

    // reset while bit 7 is on the line
    start_load(16'hA5C3, 2'd0);
    nst = 0;
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      if (oBitStrobe) nst++;
      if (nst == 8) begin
        seen = 1;
        break;
      end
      @(negedge iClkIN);
    end
    chk("rst_mid_reached", seen, 1);
    reset = 1'b0;
    @(negedge iClkIN);
    chk("rst_mid_ser", oSerOut, 1);
    chk("rst_mid_busy", oBusy, 0);
    chk("rst_mid_done", oDone, 0);
    chk("rst_mid_stb", oBitStrobe, 0);
    reset = 1'b1;
    quiet(30, "rst_mid_no_done");
    start_load(16'h5A3C, 2'd1);
    capture(2'd1, 1'b0, 1'b0, 16'h0, 2'd0);
    analyze(16'h5A3C, 2'd1, flen, lb);
    chk("after_rst_len", flen, NB*4);

    for (int i = 0; i < 12; i++) begin
      rw = 16'($urandom);
      rr = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 5)) @(negedge iClkIN);
      start_load(rw, rr);
      capture(rr, 1'($urandom_range(0, 1)), 1'b0, 16'h0, 2'd0);
      analyze(rw, rr, flen, lb);
      chk($sformatf("rnd%0d_last", i), lb,
          PAR ? int'(^rw) : int'(rw[0]));
      @(negedge iClkIN);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
